// File: rtl/ultrasound_pkg.sv
// Shared types and constants for the ultrasound ping scheduler.
package ultrasound_pkg;

  localparam int CLK_HZ = 27000000;
  localparam int IDX_W = 4;
  localparam logic [7:0] NO_RETURN = 8'hFF;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SELECT      = 3'd1,
    START       = 3'd2,
    WAIT_RESULT = 3'd3,
    HOLDOFF     = 3'd4,
    FINISH      = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ultrasound_ping_scheduler_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cycle_timer
  import ultrasound_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/ultrasound_ping_scheduler.sv
// Pings sensors one at a time through a shared ranging engine, with retries and holdoff.
// Define ULTRASOUND_SCHED_STATS_EN to count failed attempts on error_count.
module ultrasound_ping_scheduler
  import ultrasound_pkg::*;
#(
  parameter int NUM_SENSORS        = 10,
  parameter int HOLDOFF_CYCLES     = 1620000,
  parameter int SCAN_PERIOD_CYCLES = 2700000,
  parameter int WATCHDOG_CYCLES    = 1100000,
  parameter int MAX_RETRIES        = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   scan_request,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  output logic                   range_start,
  output logic [IDX_W-1:0]       range_sel,
  input  logic                   range_valid,
  input  logic                   range_error,
  input  logic [7:0]             range_distance,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       result_sensor,
  output logic [7:0]             result_distance,
  output logic                   result_error,
  output logic [IDX_W-1:0]       nearest_sensor,
  output logic [7:0]             nearest_distance,
  output logic                   scan_done,
  output logic [15:0]            error_count,
  output logic [2:0]             state
);

  localparam int TMR_W = 32;
  localparam int CNT_W = IDX_W + 1;
  localparam int RTY_W = 4;
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLDOFF_CYCLES);
  localparam logic [TMR_W-1:0] WDOG_LOAD   = TMR_W'(WATCHDOG_CYCLES);
  localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(SCAN_PERIOD_CYCLES);
  localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRIES);

  sched_state_e           state_q, state_d;
  logic [NUM_SENSORS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic                   retrying_q, retrying_d;
  logic [7:0]             best_q, best_d;
  logic [IDX_W-1:0]       best_idx_q, best_idx_d;
  logic                   result_valid_q, result_valid_d;
  logic [IDX_W-1:0]       result_sensor_q, result_sensor_d;
  logic [7:0]             result_distance_q, result_distance_d;
  logic                   result_error_q, result_error_d;
  logic [IDX_W-1:0]       nearest_sensor_q, nearest_sensor_d;
  logic [7:0]             nearest_distance_q, nearest_distance_d;

  logic                   found;
  logic [IDX_W-1:0]       found_idx;
  logic                   tmr_load, tmr_expired;
  logic [TMR_W-1:0]       tmr_value;
  logic                   per_load, per_expired;
  logic                   ok_evt, fail_evt;

  // Holdoff and watchdog never run at the same time, so they share one counter.
  cycle_timer #(.WIDTH(TMR_W)) u_step_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  cycle_timer #(.WIDTH(TMR_W)) u_period_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (per_load),
    .load_value (PERIOD_LOAD),
    .expired    (per_expired)
  );

  // Descending scan so the last hit wins, leaving the lowest eligible index.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask_q[i] && (CNT_W'(i) >= idx_q)) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  assign ok_evt   = (state_q == WAIT_RESULT) && range_valid && !range_error &&
                    (range_distance != 8'd0);
  assign fail_evt = (state_q == WAIT_RESULT) &&
                    ((range_valid && (range_error || range_distance == 8'd0)) ||
                     (!range_valid && tmr_expired));

  always_comb begin
    state_d            = state_q;
    mask_d             = mask_q;
    idx_d              = idx_q;
    sel_d              = sel_q;
    retry_d            = retry_q;
    retrying_d         = retrying_q;
    best_d             = best_q;
    best_idx_d         = best_idx_q;
    result_valid_d     = 1'b0;
    result_sensor_d    = result_sensor_q;
    result_distance_d  = result_distance_q;
    result_error_d     = result_error_q;
    nearest_sensor_d   = nearest_sensor_q;
    nearest_distance_d = nearest_distance_q;
    tmr_load           = 1'b0;
    tmr_value          = HOLD_LOAD;
    per_load           = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_request || (enable && per_expired)) begin
          mask_d     = sensor_mask;
          idx_d      = '0;
          retry_d    = '0;
          retrying_d = 1'b0;
          best_d     = NO_RETURN;
          best_idx_d = '0;
          per_load   = 1'b1;
          state_d    = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          sel_d   = found_idx;
          state_d = START;
        end else begin
          state_d = FINISH;
        end
      end
      START: begin
        tmr_load  = 1'b1;
        tmr_value = WDOG_LOAD;
        state_d   = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (fail_evt) begin
          tmr_load = 1'b1;
          state_d  = HOLDOFF;
          if (retry_q < RETRY_LIMIT) begin
            retry_d    = retry_q + RTY_W'(1);
            retrying_d = 1'b1;
          end else begin
            retrying_d        = 1'b0;
            result_valid_d    = 1'b1;
            result_sensor_d   = sel_q;
            result_distance_d = NO_RETURN;
            result_error_d    = 1'b1;
          end
        end else if (ok_evt) begin
          tmr_load          = 1'b1;
          state_d           = HOLDOFF;
          retrying_d        = 1'b0;
          result_valid_d    = 1'b1;
          result_sensor_d   = sel_q;
          result_distance_d = range_distance;
          result_error_d    = 1'b0;
          if (range_distance < best_q) begin
            best_d     = range_distance;
            best_idx_d = sel_q;
          end
        end
      end
      HOLDOFF: begin
        if (tmr_expired) begin
          if (retrying_q) begin
            retrying_d = 1'b0;
            state_d    = START;
          end else begin
            retry_d = '0;
            idx_d   = {1'b0, sel_q} + CNT_W'(1);
            state_d = SELECT;
          end
        end
      end
      FINISH: begin
        nearest_sensor_d   = best_idx_q;
        nearest_distance_d = best_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= IDLE;
      mask_q             <= '0;
      idx_q              <= '0;
      sel_q              <= '0;
      retry_q            <= '0;
      retrying_q         <= 1'b0;
      best_q             <= NO_RETURN;
      best_idx_q         <= '0;
      result_valid_q     <= 1'b0;
      result_sensor_q    <= '0;
      result_distance_q  <= '0;
      result_error_q     <= 1'b0;
      nearest_sensor_q   <= '0;
      nearest_distance_q <= NO_RETURN;
    end else begin
      state_q            <= state_d;
      mask_q             <= mask_d;
      idx_q              <= idx_d;
      sel_q              <= sel_d;
      retry_q            <= retry_d;
      retrying_q         <= retrying_d;
      best_q             <= best_d;
      best_idx_q         <= best_idx_d;
      result_valid_q     <= result_valid_d;
      result_sensor_q    <= result_sensor_d;
      result_distance_q  <= result_distance_d;
      result_error_q     <= result_error_d;
      nearest_sensor_q   <= nearest_sensor_d;
      nearest_distance_q <= nearest_distance_d;
    end
  end

`ifdef ULTRASOUND_SCHED_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (fail_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign error_count = err_cnt_q;
`else
  assign error_count = 16'h0000;
`endif

  // Gated by reset so no ping leaves in the cycle that reset is being sampled.
  assign range_start      = (state_q == START) && reset;
  assign range_sel        = sel_q;
  assign result_valid     = result_valid_q;
  assign result_sensor    = result_sensor_q;
  assign result_distance  = result_distance_q;
  assign result_error     = result_error_q;
  assign nearest_sensor   = nearest_sensor_q;
  assign nearest_distance = nearest_distance_q;
  assign scan_done        = (state_q == FINISH);
  assign state            = state_q;

endmodule

// File: tb/tb_ultrasound_ping_scheduler.sv
// Self-checking bench for ultrasound_ping_scheduler: table of scripted scans plus
// hand sequences for empty mask, continuous mode and mid-scan reset.
module tb_ultrasound_ping_scheduler;

  localparam int HOLD = 4;
  localparam int PERIOD = 40;
  localparam int WDOG = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        scan_request;
  logic [9:0]  sensor_mask;
  logic        range_start;
  logic [3:0]  range_sel;
  logic        range_valid;
  logic        range_error;
  logic [7:0]  range_distance;
  logic        result_valid;
  logic [3:0]  result_sensor;
  logic [7:0]  result_distance;
  logic        result_error;
  logic [3:0]  nearest_sensor;
  logic [7:0]  nearest_distance;
  logic        scan_done;
  logic [15:0] error_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_errs = 0;

  always #5 clock = ~clock;

  ultrasound_ping_scheduler #(
    .NUM_SENSORS        (10),
    .HOLDOFF_CYCLES     (HOLD),
    .SCAN_PERIOD_CYCLES (PERIOD),
    .WATCHDOG_CYCLES    (WDOG),
    .MAX_RETRIES        (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .scan_request     (scan_request),
    .sensor_mask      (sensor_mask),
    .range_start      (range_start),
    .range_sel        (range_sel),
    .range_valid      (range_valid),
    .range_error      (range_error),
    .range_distance   (range_distance),
    .result_valid     (result_valid),
    .result_sensor    (result_sensor),
    .result_distance  (result_distance),
    .result_error     (result_error),
    .nearest_sensor   (nearest_sensor),
    .nearest_distance (nearest_distance),
    .scan_done        (scan_done),
    .error_count      (error_count),
    .state            (state)
  );

  // One scripted scan: engine replies per attempt, plus the expected pings and results.
  typedef struct {
    logic [9:0]       mask;
    logic [3:0]       resp_silent;
    logic [3:0]       resp_err;
    logic [3:0][7:0]  resp_dist;
    int               exp_pings;
    logic [3:0][3:0]  exp_sel;
    int               exp_results;
    logic [1:0][3:0]  exp_sensor;
    logic [1:0][7:0]  exp_dist;
    logic [1:0]       exp_err;
    logic [3:0]       exp_near_s;
    logic [7:0]       exp_near_d;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkErrCount(input string name);
`ifdef ULTRASOUND_SCHED_STATS_EN
    checkOutput(name, 32'(error_count), 32'(exp_errs));
`else
    checkOutput(name, 32'(error_count), 32'd0);
`endif
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    int  pings = 0;
    int  nres = 0;
    int  wait_cnt = -1;
    int  resp = 0;
    int  last_start = -1;
    int  min_gap = 1000;
    bit  done = 1'b0;
    sensor_mask  = v.mask;
    scan_request = 1'b1;
    step();
    scan_request = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      range_valid    = 1'b0;
      range_error    = 1'b0;
      range_distance = 8'd0;
      if (range_start) begin
        if (pings < 4)
          checkOutput($sformatf("v%0d range_sel ping%0d", id, pings),
                      32'(range_sel), 32'(v.exp_sel[pings]));
        if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
        last_start = cyc;
        pings++;
        wait_cnt = 2;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end else if (wait_cnt == 0) begin
        wait_cnt = -1;
        if (resp < 4) begin
          if (v.resp_silent[resp]) begin
            exp_errs++;
          end else begin
            range_valid    = 1'b1;
            range_error    = v.resp_err[resp];
            range_distance = v.resp_dist[resp];
            if (v.resp_err[resp] || v.resp_dist[resp] == 8'd0) exp_errs++;
          end
        end
        resp++;
      end
      if (result_valid) begin
        if (nres < 2) begin
          checkOutput($sformatf("v%0d result_sensor%0d", id, nres),
                      32'(result_sensor), 32'(v.exp_sensor[nres]));
          checkOutput($sformatf("v%0d result_distance%0d", id, nres),
                      32'(result_distance), 32'(v.exp_dist[nres]));
          checkOutput($sformatf("v%0d result_error%0d", id, nres),
                      32'(result_error), 32'(v.exp_err[nres]));
        end
        nres++;
      end
      if (scan_done) done = 1'b1;
      else step();
    end
    checkOutput($sformatf("v%0d scan_done seen", id), 32'(done), 32'd1);
    checkOutput($sformatf("v%0d ping count", id), 32'(pings), 32'(v.exp_pings));
    checkOutput($sformatf("v%0d result count", id), 32'(nres), 32'(v.exp_results));
    if (pings > 1)
      checkOutput($sformatf("v%0d ping spacing>=%0d (min %0d)", id, HOLD, min_gap),
                  32'(min_gap >= HOLD), 32'd1);
    step();
    checkOutput($sformatf("v%0d scan_done single pulse", id), 32'(scan_done), 32'd0);
    checkOutput($sformatf("v%0d back to idle", id), 32'(state), 32'd0);
    if (v.exp_near_d != 8'hFF)
      checkOutput($sformatf("v%0d nearest_sensor", id), 32'(nearest_sensor), 32'(v.exp_near_s));
    checkOutput($sformatf("v%0d nearest_distance", id), 32'(nearest_distance), 32'(v.exp_near_d));
    checkErrCount($sformatf("v%0d error_count", id));
  endtask

  initial begin
    vecs[0] = '{mask: 10'b0000000101, resp_silent: 4'b0000, resp_err: 4'b0000,
                resp_dist: {8'd0, 8'd0, 8'd12, 8'd30}, exp_pings: 2,
                exp_sel: {4'd0, 4'd0, 4'd2, 4'd0}, exp_results: 2,
                exp_sensor: {4'd2, 4'd0}, exp_dist: {8'd12, 8'd30}, exp_err: 2'b00,
                exp_near_s: 4'd2, exp_near_d: 8'd12};
    vecs[1] = '{mask: 10'b0000000001, resp_silent: 4'b0000, resp_err: 4'b0011,
                resp_dist: {8'd0, 8'd25, 8'd9, 8'd9}, exp_pings: 3,
                exp_sel: 16'h0000, exp_results: 1,
                exp_sensor: {4'd0, 4'd0}, exp_dist: {8'd0, 8'd25}, exp_err: 2'b00,
                exp_near_s: 4'd0, exp_near_d: 8'd25};
    vecs[2] = '{mask: 10'b0000000001, resp_silent: 4'b0111, resp_err: 4'b0000,
                resp_dist: 32'h0, exp_pings: 3,
                exp_sel: 16'h0000, exp_results: 1,
                exp_sensor: {4'd0, 4'd0}, exp_dist: {8'd0, 8'hFF}, exp_err: 2'b01,
                exp_near_s: 4'd0, exp_near_d: 8'hFF};
    vecs[3] = '{mask: 10'b1000000010, resp_silent: 4'b0000, resp_err: 4'b0100,
                resp_dist: {8'd40, 8'd40, 8'd50, 8'd0}, exp_pings: 4,
                exp_sel: {4'd9, 4'd9, 4'd1, 4'd1}, exp_results: 2,
                exp_sensor: {4'd9, 4'd1}, exp_dist: {8'd40, 8'd50}, exp_err: 2'b00,
                exp_near_s: 4'd9, exp_near_d: 8'd40};
    vecs[4] = '{mask: 10'b0000000010, resp_silent: 4'b0000, resp_err: 4'b0000,
                resp_dist: {8'd0, 8'd0, 8'd0, 8'hFF}, exp_pings: 1,
                exp_sel: {4'd0, 4'd0, 4'd0, 4'd1}, exp_results: 1,
                exp_sensor: {4'd0, 4'd1}, exp_dist: {8'd0, 8'hFF}, exp_err: 2'b00,
                exp_near_s: 4'd0, exp_near_d: 8'hFF};
    vecs[5] = '{mask: 10'b0000011000, resp_silent: 4'b0000, resp_err: 4'b0000,
                resp_dist: {8'd0, 8'd0, 8'd7, 8'd7}, exp_pings: 2,
                exp_sel: {4'd0, 4'd0, 4'd4, 4'd3}, exp_results: 2,
                exp_sensor: {4'd4, 4'd3}, exp_dist: {8'd7, 8'd7}, exp_err: 2'b00,
                exp_near_s: 4'd3, exp_near_d: 8'd7};

    reset = 1'b0; enable = 1'b0; scan_request = 1'b0; sensor_mask = '0;
    range_valid = 1'b0; range_error = 1'b0; range_distance = 8'd0;
    repeat (3) step();
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset range_start", 32'(range_start), 32'd0);
    checkOutput("reset range_sel", 32'(range_sel), 32'd0);
    checkOutput("reset result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset nearest_distance", 32'(nearest_distance), 32'hFF);
    checkOutput("reset scan_done", 32'(scan_done), 32'd0);
    checkErrCount("reset error_count");
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    begin : empty_mask
      int  done_at = -1;
      bit  started = 1'b0;
      sensor_mask  = '0;
      scan_request = 1'b1;
      for (int i = 1; i <= 10 && done_at < 0; i++) begin
        step();
        scan_request = 1'b0;
        if (range_start) started = 1'b1;
        if (scan_done) done_at = i;
      end
      checkOutput("empty mask scan_done latency", 32'(done_at), 32'd2);
      checkOutput("empty mask no range_start", 32'(started), 32'd0);
      step();
      checkOutput("empty mask nearest_distance", 32'(nearest_distance), 32'hFF);
    end

    begin : continuous
      int  starts = 0;
      int  dones = 0;
      int  last_start = -1;
      int  min_gap = 1000;
      int  wait_cnt = -1;
      logic [2:0] prev_state;
      bit  stray = 1'b0;
      sensor_mask = 10'b0000000011;
      enable = 1'b1;
      prev_state = state;
      for (int cyc = 0; cyc < 400 && dones < 3; cyc++) begin
        range_valid = 1'b0; range_error = 1'b0; range_distance = 8'd0;
        if (state == 3'd1 && prev_state == 3'd0) begin
          if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
          last_start = cyc;
          starts++;
        end
        prev_state = state;
        if (range_start) begin
          wait_cnt = 2;
          if (dones == 2) enable = 1'b0;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end else if (wait_cnt == 0) begin
          wait_cnt = -1;
          range_valid = 1'b1;
          range_distance = 8'd20;
        end
        if (scan_done) dones++;
        if (dones < 3) step();
      end
      step();
      checkOutput("continuous scans completed", 32'(dones), 32'd3);
      checkOutput("continuous scans started", 32'(starts), 32'd3);
      checkOutput($sformatf("continuous period>=%0d (min %0d)", PERIOD, min_gap),
                  32'(min_gap >= PERIOD), 32'd1);
      checkOutput("continuous tie nearest_sensor", 32'(nearest_sensor), 32'd0);
      checkOutput("continuous nearest_distance", 32'(nearest_distance), 32'd20);
      for (int i = 0; i < 60; i++) begin
        step();
        if (range_start || state != 3'd0) stray = 1'b1;
      end
      checkOutput("enable low stays idle", 32'(stray), 32'd0);
    end

    begin : reset_gating
      bit seen = 1'b0;
      sensor_mask = 10'b0000000001;
      scan_request = 1'b1;
      step();
      scan_request = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (range_start) seen = 1'b1;
        else step();
      end
      checkOutput("gating reached START", 32'(seen), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("range_start low while reset sampled", 32'(range_start), 32'd0);
      step();
      reset = 1'b1;
      step();
    end

    begin : reset_in_wait
      bit seen = 1'b0;
      bit late = 1'b0;
      sensor_mask = 10'b0000000001;
      scan_request = 1'b1;
      step();
      scan_request = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (range_start) seen = 1'b1;
        step();
      end
      checkOutput("mid-scan in WAIT_RESULT", 32'(state), 32'd3);
      reset = 1'b0;
      step();
      checkOutput("mid reset state", 32'(state), 32'd0);
      checkOutput("mid reset result_valid", 32'(result_valid), 32'd0);
      checkOutput("mid reset result_distance", 32'(result_distance), 32'd0);
      checkOutput("mid reset result_sensor", 32'(result_sensor), 32'd0);
      checkOutput("mid reset result_error", 32'(result_error), 32'd0);
      checkOutput("mid reset nearest_sensor", 32'(nearest_sensor), 32'd0);
      checkOutput("mid reset nearest_distance", 32'(nearest_distance), 32'hFF);
      checkOutput("mid reset range_sel", 32'(range_sel), 32'd0);
      checkOutput("mid reset error_count", 32'(error_count), 32'd0);
      reset = 1'b1;
      range_valid = 1'b1;
      range_distance = 8'd10;
      step();
      range_valid = 1'b0;
      range_distance = 8'd0;
      for (int i = 0; i < 5; i++) begin
        if (result_valid || range_start) late = 1'b1;
        step();
      end
      checkOutput("late range_valid ignored", 32'(late), 32'd0);
      checkOutput("idle after late range_valid", 32'(state), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
